// File: rtl/op_sequencer_pkg.sv
// Shared definitions for the operand sequencer: default sizing and FSM state encoding.
package op_sequencer_pkg;

  localparam int unsigned DEF_W       = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4
  } state_e;

endpackage

// File: rtl/op_sequencer_fifo.sv
// Operand FIFO: DEPTH x W circular buffer. Push is refused when full and pop is
// ignored when empty. Also exposes the next-cycle occupancy so the owner can
// register its ready flag without a combinational path to the port.
module op_sequencer_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify the handshakes against full/empty and work out the next occupancy.
  always_comb begin
    do_push_s = push_i && (count_q != CW'(DEPTH));
    do_pop_s  = pop_i && (count_q != '0);
    count_d   = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers (wrap naturally because DEPTH is a power of two) and count.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/op_sequencer.sv
// Operand sequencer: queues operands and runs one controller job at a time.
// Each job re-arms the controller (ctl_rst), pulses START, waits for finished
// (bounded by TIMEOUT) and presents the captured result on a valid/ready port.
// The operand stays in the FIFO until its job ends so count includes the job
// in flight. All outputs are registered, decoded from the next state.
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_x,
  output logic                   ctl_rst,
  output logic                   START,
  output logic [W-1:0]           x_out,
  input  logic                   finished,
  input  logic [W-1:0]           result_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           result,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          ctl_rst_q, ctl_rst_d;
  logic          start_q, start_d;
  logic [W-1:0]  x_out_q, x_out_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  result_q, result_d;
  logic          timeout_err_q, timeout_err_d;
  logic          in_ready_q, in_ready_d;

  logic          push_s;
  logic          pop_s;
  logic [W-1:0]  head_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_next_s;

  assign push_s = in_valid && in_ready_q;

  op_sequencer_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .RST          (RST),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .data_i       (in_x),
    .head_o       (head_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

  // Job FSM: next state, wait counter, result capture and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_s != '0) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        // A finished seen on the last allowed cycle still counts as success.
        if (finished) begin
          result_d = result_in;
          pop_s    = 1'b1;
          state_d  = ST_OUTPUT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          pop_s         = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop.
  always_comb begin
    ctl_rst_d   = (state_d == ST_ARM);
    start_d     = (state_d == ST_LAUNCH);
    out_valid_d = (state_d == ST_OUTPUT);
    in_ready_d  = (count_next_s < CW'(DEPTH));
    if (state_d == ST_ARM) begin
      x_out_d = head_s;
    end else begin
      x_out_d = x_out_q;
    end
  end

  // State and output registers; reset drops any job and clears every output.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      ctl_rst_q     <= 1'b0;
      start_q       <= 1'b0;
      x_out_q       <= '0;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      ctl_rst_q     <= ctl_rst_d;
      start_q       <= start_d;
      x_out_q       <= x_out_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign ctl_rst     = ctl_rst_q;
  assign START       = start_q;
  assign x_out       = x_out_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign timeout_err = timeout_err_q;
  assign count       = count_s;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: the bench plays the controller/datapath,
// drives operands and checks against hand-computed expectations.
module tb_op_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic       ctl_rst;
  logic       START;
  logic [7:0] x_out;
  logic       finished;
  logic [7:0] result_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       timeout_err;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;
  int n_arm    = 0;
  int n_start  = 0;
  int n_outv   = 0;

  op_sequencer #(
    .W       (8),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .RST         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .ctl_rst     (ctl_rst),
    .START       (START),
    .x_out       (x_out),
    .finished    (finished),
    .result_in   (result_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .timeout_err (timeout_err),
    .count       (count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/level counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ctl_rst)   n_arm++;
    if (START)     n_start++;
    if (out_valid) n_outv++;
  end

  // Hard stop in case the run gets stuck.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_checks++;
    if (obs !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for START; then drop the previous job's finished level,
  // as a re-armed controller would.
  task automatic wait_start();
    int n = 0;
    while (!START && n < 40) begin
      step();
      n++;
    end
    check_eq("start_seen", 32'(START), 32'd1);
    finished = 1'b0;
  endtask

  // One job: finished first seen in WAIT cycle lat, result res, operand exp_x.
  task automatic run_job(input int lat, input logic [7:0] res, input logic [7:0] exp_x);
    wait_start();
    check_eq("job_x_out", 32'(x_out), 32'(exp_x));
    repeat (lat + 1) step();
    finished  = 1'b1;
    result_in = res;
    step();
    check_eq("job_out_valid", 32'(out_valid), 32'd1);
    check_eq("job_result", 32'(result), 32'(res));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("job_out_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int s0;
    int a0;
    int o0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 8'd0;
    finished  = 1'b0;
    result_in = 8'd0;
    out_ready = 1'b0;

    // Reset state.
    step();
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step();
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single job with latency checks.
    in_valid = 1'b1;
    in_x     = 8'd5;
    step();
    in_valid = 1'b0;
    check_eq("single_count1", 32'(count), 32'd1);
    check_eq("single_no_arm_yet", 32'(ctl_rst), 32'd0);
    step();
    check_eq("single_ctl_rst", 32'(ctl_rst), 32'd1);
    check_eq("single_x_out_arm", 32'(x_out), 32'd5);
    check_eq("single_no_start_yet", 32'(START), 32'd0);
    step();
    check_eq("single_start", 32'(START), 32'd1);
    check_eq("single_ctl_rst_drop", 32'(ctl_rst), 32'd0);
    repeat (7) step();
    check_eq("single_x_out_wait", 32'(x_out), 32'd5);
    check_eq("single_start_once", 32'(START), 32'd0);
    finished  = 1'b1;
    result_in = 8'h19;
    check_eq("single_not_valid_yet", 32'(out_valid), 32'd0);
    step();
    check_eq("single_out_valid", 32'(out_valid), 32'd1);
    check_eq("single_result", 32'(result), 32'h19);
    check_eq("single_count0", 32'(count), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("single_out_drop", 32'(out_valid), 32'd0);
    check_eq("single_arm_pulses", 32'(n_arm), 32'd1);
    check_eq("single_start_pulses", 32'(n_start), 32'd1);

    // Order: three queued operands, results leave in order, one START each.
    s0 = n_start;
    a0 = n_arm;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_x = 8'(i);
      step();
    end
    in_valid = 1'b0;
    run_job(3, 8'h11, 8'd1);
    run_job(0, 8'h22, 8'd2);
    run_job(5, 8'h33, 8'd3);
    check_eq("order_starts", 32'(n_start - s0), 32'd3);
    check_eq("order_arms", 32'(n_arm - a0), 32'd3);

    // Backpressure: result held, queued job not armed until handshake.
    in_valid = 1'b1;
    in_x     = 8'd7;
    step();
    in_valid = 1'b0;
    wait_start();
    step();
    finished  = 1'b1;
    result_in = 8'h42;
    step();
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_x     = 8'd8;
    step();
    in_valid  = 1'b0;
    result_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_result", 32'(result), 32'h42);
      check_eq("bp_no_arm", 32'(ctl_rst), 32'd0);
      step();
    end
    check_eq("bp_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_out_drop", 32'(out_valid), 32'd0);
    run_job(2, 8'h55, 8'd8);

    // Timeout: finished never rises for x=9, then x=10 runs normally.
    in_valid = 1'b1;
    in_x     = 8'd9;
    step();
    in_x = 8'd10;
    step();
    in_valid = 1'b0;
    wait_start();
    step();
    repeat (15) step();
    check_eq("to_not_yet", 32'(timeout_err), 32'd0);
    check_eq("to_count_before", 32'(count), 32'd2);
    step();
    check_eq("to_set", 32'(timeout_err), 32'd1);
    check_eq("to_popped", 32'(count), 32'd1);
    check_eq("to_no_out_valid", 32'(out_valid), 32'd0);
    run_job(1, 8'h66, 8'd10);
    check_eq("to_sticky", 32'(timeout_err), 32'd1);

    // Fill: fifth operand held off while the first job waits.
    finished = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_x = 8'(8'h20 + i);
      step();
    end
    in_valid = 1'b0;
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    check_eq("fill_x_out", 32'(x_out), 32'h21);

    // Reset mid-WAIT with queued operands: everything cleared, nothing emitted.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("mid_rst_ctl_rst", 32'(ctl_rst), 32'd0);
    check_eq("mid_rst_start", 32'(START), 32'd0);
    check_eq("mid_rst_x_out", 32'(x_out), 32'd0);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_result", 32'(result), 32'd0);
    check_eq("mid_rst_timeout", 32'(timeout_err), 32'd0);
    o0 = n_outv;
    a0 = n_arm;
    repeat (30) step();
    check_eq("post_rst_no_out", 32'(n_outv - o0), 32'd0);
    check_eq("post_rst_no_arm", 32'(n_arm - a0), 32'd0);
    check_eq("post_rst_count", 32'(count), 32'd0);
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
